// File: rtl/sorting_top_gen2.sv
// sorting_top_gen2: in-place early-exit bubble sorter over a 2^L x N register file
// Ports: clk/rst (async active-high), host port WrInit/Rd/RAddr/DataIn -> DataOut (1-cycle read),
//        start/Len/Desc launch a sort of M[0..min(Len,2^L)-1]; busy during the sort, done pulses once.
// Build option: define SORT_SIGNED_EN to compare words as two's complement (unsigned otherwise).
module sorting_top_gen2 #(
  parameter int N = 16,
  parameter int L = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         WrInit,
  input  logic         Rd,
  input  logic [L-1:0] RAddr,
  input  logic [N-1:0] DataIn,
  input  logic         start,
  input  logic [L:0]   Len,
  input  logic         Desc,
  output logic [N-1:0] DataOut,
  output logic         busy,
  output logic         done
);
  localparam int D = 2 ** L;
  localparam logic [L:0] DEPTH = (L + 1)'(D);
  localparam logic [L:0] LEN1 = (L + 1)'(1);
  localparam logic [L-1:0] ONE = L'(1);
  typedef enum logic [2:0] {IDLE, LOAD, CMP, PASS, DONE} state_t;
  state_t r_state, w_next;
  logic [N-1:0] r_mem [D];
  logic [N-1:0] r_a, r_b;
  logic [L-1:0] r_j, r_last, w_j1, w_last;
  logic r_desc, r_swapped;
  logic [L:0] w_len;
  logic w_gt, w_lt, w_ooo, w_end_pass;
  assign w_len = (Len > DEPTH) ? DEPTH : Len;
  // a full-depth length wraps to 0 in L bits, so subtracting one still yields 2^L-1
  assign w_last = w_len[L-1:0] - ONE;
  assign w_j1 = r_j + ONE;
`ifdef SORT_SIGNED_EN
  assign w_gt = $signed(r_a) > $signed(r_b);
  assign w_lt = $signed(r_a) < $signed(r_b);
`else
  assign w_gt = r_a > r_b;
  assign w_lt = r_a < r_b;
`endif
  // strict compare: equal keys stay in place, keeping the sort stable
  assign w_ooo = r_desc ? w_lt : w_gt;
  assign w_end_pass = r_j == r_last - ONE;
  assign busy = r_state == LOAD || r_state == CMP || r_state == PASS;
  assign done = r_state == DONE;
  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: w_next = start ? ((w_len <= LEN1) ? DONE : LOAD) : IDLE;
      LOAD: w_next = CMP;
      CMP:  w_next = w_end_pass ? PASS : LOAD;
      PASS: w_next = (!r_swapped || r_last == ONE) ? DONE : LOAD;
      DONE: w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      for (int i = 0; i < D; i++) r_mem[i] <= '0;
      DataOut   <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_j       <= '0;
      r_last    <= '0;
      r_desc    <= 1'b0;
      r_swapped <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE:
          if (start) begin
            r_desc    <= Desc;
            r_last    <= w_last;
            r_j       <= '0;
            r_swapped <= 1'b0;
          end else begin
            if (WrInit) r_mem[RAddr] <= DataIn;
            if (Rd) DataOut <= r_mem[RAddr];
          end
        LOAD: begin
          r_a <= r_mem[r_j];
          r_b <= r_mem[w_j1];
        end
        CMP: begin
          if (w_ooo) begin
            r_mem[r_j] <= r_b;
            r_mem[w_j1] <= r_a;
            r_swapped <= 1'b1;
          end
          if (!w_end_pass) r_j <= w_j1;
        end
        PASS:
          if (w_next == LOAD) begin
            r_last    <= r_last - ONE;
            r_j       <= '0;
            r_swapped <= 1'b0;
          end
        default: ;
      endcase
    end
endmodule

// File: tb/tb_sorting_top_gen2.sv
// tb_sorting_top_gen2: scoreboard bench for sorting_top_gen2 with directed vectors
module tb_sorting_top_gen2;
  localparam int N = 16;
  localparam int L = 4;
  logic clk = 1'b0, rst = 1'b1, WrInit = 1'b0, Rd = 1'b0, start = 1'b0, Desc = 1'b0;
  logic [L-1:0] RAddr = '0;
  logic [N-1:0] DataIn = '0;
  logic [L:0] Len = '0;
  logic [N-1:0] DataOut;
  logic busy, done;
  typedef struct {string nm; logic [N-1:0] v;} exp_t;
  exp_t sb[$];
  exp_t e_pop;
  logic rdv = 1'b0, rd_d = 1'b0;
  int n_tests = 0, n_fail = 0;
  int cnt;
  logic [N-1:0] p[5] = '{16'd9, 16'd5, 16'd5, 16'd2, 16'd7};
  logic [N-1:0] p_exp[5] = '{16'd2, 16'd5, 16'd5, 16'd9, 16'd7};

  sorting_top_gen2 #(.N(N), .L(L)) dut (
    .clk(clk), .rst(rst), .WrInit(WrInit), .Rd(Rd), .RAddr(RAddr), .DataIn(DataIn),
    .start(start), .Len(Len), .Desc(Desc), .DataOut(DataOut), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(posedge clk) rd_d <= Rd && rdv;
  always @(negedge clk)
    if (rd_d) begin
      if (sb.size() == 0) chk("unexpected read", 32'd1, 32'd0);
      else begin
        e_pop = sb.pop_front();
        chk(e_pop.nm, {16'd0, DataOut}, {16'd0, e_pop.v});
      end
    end

  task automatic push(input logic [N-1:0] e, input string nm);
    exp_t x;
    x.nm = nm;
    x.v = e;
    sb.push_back(x);
  endtask

  task automatic wr(input logic [L-1:0] a, input logic [N-1:0] d);
    RAddr = a; DataIn = d; WrInit = 1'b1;
    @(negedge clk);
    WrInit = 1'b0;
  endtask

  task automatic rd(input logic [L-1:0] a, input logic [N-1:0] e, input string nm);
    push(e, nm);
    RAddr = a; Rd = 1'b1; rdv = 1'b1;
    @(negedge clk);
    Rd = 1'b0; rdv = 1'b0;
  endtask

  task automatic go(input logic [L:0] n, input logic d);
    Len = n; Desc = d; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic finish_sort(input int t, input int elapsed, input string nm);
    int c = elapsed;
    while (!done && c < 5000) begin
      @(negedge clk);
      c++;
    end
    chk({nm, " latency"}, c, t);
    chk({nm, " busy in done"}, {31'd0, busy}, 32'd0);
    @(negedge clk);
    chk({nm, " done one cycle"}, {31'd0, done}, 32'd0);
  endtask

  task automatic sort(input logic [L:0] n, input logic d, input int t, input string nm);
    go(n, d);
    chk({nm, " busy"}, {31'd0, busy}, (t > 0) ? 32'd1 : 32'd0);
    finish_sort(t, 0, nm);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("reset busy", {31'd0, busy}, 32'd0);
    chk("reset done", {31'd0, done}, 32'd0);
    chk("reset dataout", {16'd0, DataOut}, 32'd0);
    rd(0, 16'd0, "reset mem");
    for (int i = 0; i < 4; i++) wr(L'(i), N'(i + 1));
    sort(4, 1'b0, 7, "sorted");
    for (int i = 0; i < 4; i++) rd(L'(i), N'(i + 1), "sorted data");
    sort(4, 1'b1, 15, "desc");
    for (int i = 0; i < 4; i++) rd(L'(i), N'(4 - i), "desc data");
    for (int i = 0; i < 5; i++) wr(L'(i), p[i]);
    sort(4, 1'b0, 15, "partial");
    for (int i = 0; i < 5; i++) rd(L'(i), p_exp[i], "partial data");
    wr(0, 16'd8);
    wr(1, 16'd3);
    sort(0, 1'b0, 0, "len0");
    sort(1, 1'b0, 0, "len1");
    rd(0, 16'd8, "len01 m0");
    rd(1, 16'd3, "len01 m1");
    push(16'd5, "wr+rd old value");
    RAddr = 2; DataIn = 16'h1234; WrInit = 1'b1; Rd = 1'b1; rdv = 1'b1;
    @(negedge clk);
    WrInit = 1'b0; Rd = 1'b0; rdv = 1'b0;
    rd(2, 16'h1234, "wr visible");
    for (int i = 0; i < 16; i++) wr(L'(i), N'(15 - i));
    sort(5'd21, 1'b0, 255, "len21");
    for (int i = 0; i < 16; i++) rd(L'(i), N'(i), "len21 data");
    rd(5, 16'd5, "pre busy read");
    go(4, 1'b1);
    chk("ign busy", {31'd0, busy}, 32'd1);
    RAddr = 0; DataIn = 16'hBEEF; WrInit = 1'b1; Rd = 1'b1; start = 1'b1; Len = 2; Desc = 1'b0;
    repeat (3) @(negedge clk);
    chk("ign dataout hold", {16'd0, DataOut}, 32'd5);
    WrInit = 1'b0; Rd = 1'b0; start = 1'b0;
    finish_sort(15, 3, "ign");
    for (int i = 0; i < 4; i++) rd(L'(i), N'(3 - i), "ign data");
    rd(4, 16'd4, "ign m4");
    wr(0, 16'h0001);
    wr(1, 16'h8000);
    sort(2, 1'b0, 3, "signed");
`ifdef SORT_SIGNED_EN
    rd(0, 16'h8000, "signed m0");
    rd(1, 16'h0001, "signed m1");
`else
    rd(0, 16'h0001, "unsigned m0");
    rd(1, 16'h8000, "unsigned m1");
`endif
    for (int i = 0; i < 16; i++) wr(L'(i), N'(100 - i));
    rd(5, 16'd95, "pre reset read");
    go(16, 1'b0);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst busy", {31'd0, busy}, 32'd0);
    chk("midrst done", {31'd0, done}, 32'd0);
    chk("midrst dataout", {16'd0, DataOut}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 16; i++) rd(L'(i), 16'd0, "midrst mem");
    @(negedge clk);
    chk("scoreboard drained", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
